// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the multiplexed seven-segment
// scanner.
//   seg7_t       - active-low segment vector, bit 0 = a ... bit 6 = g
//   SEG_BLANK    - all segments dark
//   HEX7_TABLE   - nibble to active-low segment pattern
//   scan_state_t - scan sequencer states
package display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: groups the scanner's strobe, data and pin signals.
//   master - system side: drives digsel/load/value/dp_in/blank_in/blink_in,
//            observes an/seg/dp/frame
//   slave  - scanner side: the reverse
interface display_scan_if
    import display_pkg::*;
#(
    parameter int NDIG = 4
);
    logic              digsel;
    logic              load;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blank_in;
    logic [NDIG-1:0]   blink_in;
    logic [NDIG-1:0]   an;
    seg7_t             seg;
    logic              dp;
    logic              frame;

    modport master (
        output digsel, load, value, dp_in, blank_in, blink_in,
        input  an, seg, dp, frame
    );

    modport slave (
        input  digsel, load, value, dp_in, blank_in, blink_in,
        output an, seg, dp, frame
    );

endinterface

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment lookup.
//   nibble - 4-bit hex digit
//   seg    - active-low segments, seg[0] = a ... seg[6] = g
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexed common-anode seven-segment scanner.
// Double-buffers a hex value (shadow -> display at each wrap) and rotates a
// one-hot anode ring on every digsel strobe. All pin outputs are registered.
//   clk    - system clock, rising edge
//   greset - asynchronous active-high reset
//   bus    - display_scan_if.slave: digsel, load, value, dp_in, blank_in,
//            blink_in in; an, seg, dp, frame out (all active-low except frame)
// Optional feature: define DISP_BLINK_EN to add frame-rate blinking of the
// digits flagged in blink_in (half-period BLINK_DIV frames).
//
// state    | meaning
// ST_IDLE  | since reset, no digsel seen; outputs dark
// ST_SCAN  | ring is rotating; outputs show the selected digit
module display_scan
    import display_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int BLINK_DIV = 64
)(
    input  logic           clk,
    input  logic           greset,
    display_scan_if.slave  bus
);

    scan_state_t       state_q, state_n;
    logic [NDIG-1:0]   ring, ring_n;
    logic              wrap;

    logic [4*NDIG-1:0] sh_val, dv_val, dv_val_n;
    logic [NDIG-1:0]   sh_dp, dv_dp, dv_dp_n;
    logic [NDIG-1:0]   sh_blank, dv_blank, dv_blank_n;
    logic [NDIG-1:0]   dark_n;

    logic [3:0]        nib;
    logic              dark_sel;
    logic              dp_sel;
    seg7_t             seg_raw;

    logic [NDIG-1:0]   an_q;
    seg7_t             seg_q;
    logic              dp_q;
    logic              frame_q;

    // Ring starts on the last digit so the first strobe is a wrap onto digit 0.
    assign wrap   = bus.digsel & ring[NDIG-1];
    assign ring_n = bus.digsel ? {ring[NDIG-2:0], ring[NDIG-1]} : ring;

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state_q <= ST_IDLE;
            ring    <= {1'b1, {(NDIG-1){1'b0}}};
        end else begin
            state_q <= state_n;
            ring    <= ring_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (bus.digsel)
            state_n = ST_SCAN;
    end

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            dv_val   <= '0;
            dv_dp    <= '0;
            dv_blank <= '0;
        end else begin
            if (bus.load) begin
                sh_val   <= bus.value;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
            end
            dv_val   <= dv_val_n;
            dv_dp    <= dv_dp_n;
            dv_blank <= dv_blank_n;
        end
    end

    // A load coinciding with the wrap goes straight to the display register,
    // otherwise the new frame would show data one load stale.
    always_comb begin
        dv_val_n   = dv_val;
        dv_dp_n    = dv_dp;
        dv_blank_n = dv_blank;
        if (wrap) begin
            if (bus.load) begin
                dv_val_n   = bus.value;
                dv_dp_n    = bus.dp_in;
                dv_blank_n = bus.blank_in;
            end else begin
                dv_val_n   = sh_val;
                dv_dp_n    = sh_dp;
                dv_blank_n = sh_blank;
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]   blink_cnt;
    logic            phase;
    logic [NDIG-1:0] sh_blink, dv_blink, dv_blink_n;
    logic            dv_phase, dv_phase_n;

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            sh_blink  <= '0;
            dv_blink  <= '0;
            dv_phase  <= 1'b0;
        end else begin
            if (bus.load)
                sh_blink <= bus.blink_in;
            if (wrap) begin
                if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            dv_blink <= dv_blink_n;
            dv_phase <= dv_phase_n;
        end
    end

    // Phase is sampled into the display register at the wrap so that a whole
    // frame uses one phase value.
    assign dv_blink_n = wrap ? (bus.load ? bus.blink_in : sh_blink) : dv_blink;
    assign dv_phase_n = wrap ? phase : dv_phase;
    assign dark_n     = dv_blank_n | (dv_blink_n & {NDIG{dv_phase_n}});
`else
    logic unused_blink;
    assign unused_blink = (^bus.blink_in) ^ (BLINK_DIV > 0);
    assign dark_n       = dv_blank_n;
`endif

    always_comb begin
        nib      = 4'h0;
        dark_sel = 1'b0;
        dp_sel   = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (ring_n[i]) begin
                nib      = dv_val_n[i*4 +: 4];
                dark_sel = dark_n[i];
                dp_sel   = dv_dp_n[i];
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg_raw)
    );

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            frame_q <= wrap;
            if (bus.digsel) begin
                an_q  <= ~ring_n;
                seg_q <= dark_sel ? SEG_BLANK : seg_raw;
                dp_q  <= dark_sel | ~dp_sel;
            end
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized and directed stimulus for display_scan, checked
// every cycle against a digit-position / frame-count reference model.
module tb_display_scan;

    localparam int NDIG      = 4;
    localparam int BLINK_DIV = 2;
`ifdef DISP_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic greset;

    display_scan_if #(.NDIG(NDIG)) bus ();

    display_scan #(.NDIG(NDIG), .BLINK_DIV(BLINK_DIV)) dut (
        .clk    (clk),
        .greset (greset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Segment patterns written from the lit-segment picture of each glyph.
    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state
    int          pos;
    int          frames;
    logic [15:0] m_sh_val,  m_fr_val;
    logic [3:0]  m_sh_dp,   m_fr_dp;
    logic [3:0]  m_sh_bl,   m_fr_bl;
    logic [3:0]  m_sh_bk,   m_fr_bk;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos      = NDIG - 1;
        frames   = 0;
        m_sh_val = '0; m_fr_val = '0;
        m_sh_dp  = '0; m_fr_dp  = '0;
        m_sh_bl  = '0; m_fr_bl  = '0;
        m_sh_bk  = '0; m_fr_bk  = '0;
        e_an     = 4'hF;
        e_seg    = 7'h7F;
        e_dp     = 1'b1;
        e_frame  = 1'b0;
    endtask

    task automatic model_edge(input logic ds, input logic ld, input logic [15:0] v,
                              input logic [3:0] dpi, input logic [3:0] bl, input logic [3:0] bk);
        logic dark;
        logic [3:0] nib;
        e_frame = 1'b0;
        if (ds) begin
            pos = (pos + 1) % NDIG;
            if (pos == 0) begin
                frames++;
                e_frame = 1'b1;
                if (ld) begin
                    m_fr_val = v; m_fr_dp = dpi; m_fr_bl = bl; m_fr_bk = bk;
                end else begin
                    m_fr_val = m_sh_val; m_fr_dp = m_sh_dp; m_fr_bl = m_sh_bl; m_fr_bk = m_sh_bk;
                end
            end
            nib  = 4'((m_fr_val >> (4 * pos)) & 16'hF);
            dark = m_fr_bl[pos] ||
                   (BLINK_EN && m_fr_bk[pos] && ((((frames - 1) / BLINK_DIV) % 2) == 1));
            e_an  = ~(4'b0001 << pos);
            e_seg = dark ? 7'h7F : seg_ref[nib];
            e_dp  = dark ? 1'b1 : ~m_fr_dp[pos];
        end
        if (ld) begin
            m_sh_val = v; m_sh_dp = dpi; m_sh_bl = bl; m_sh_bk = bk;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_an"},    32'(bus.an),    32'(e_an));
        check({tag, "_seg"},   32'(bus.seg),   32'(e_seg));
        check({tag, "_dp"},    32'(bus.dp),    32'(e_dp));
        check({tag, "_frame"}, 32'(bus.frame), 32'(e_frame));
    endtask

    // One clock: drive inputs, take the edge, update the model, then compare.
    task automatic step(input string tag, input logic ds, input logic ld, input logic [15:0] v,
                        input logic [3:0] dpi, input logic [3:0] bl, input logic [3:0] bk);
        bus.digsel   = ds;
        bus.load     = ld;
        bus.value    = v;
        bus.dp_in    = dpi;
        bus.blank_in = bl;
        bus.blink_in = bk;
        @(posedge clk);
        if (greset) model_reset();
        else        model_edge(ds, ld, v, dpi, bl, bk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        greset = 1'b1;
        step("rst", 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        step("rst", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        greset = 1'b0;
    endtask

    initial begin
        greset       = 1'b1;
        bus.digsel   = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.blink_in = '0;
        model_reset();
        do_reset();

        // Idle after reset: everything dark.
        for (int i = 0; i < 100; i++)
            step("idle", 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

        // Load then one frame.
        step("load1a80", 1'b0, 1'b1, 16'h1A80, 4'h0, 4'h0, 4'h0);
        step("d0", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("d0_lit_seg", 32'(bus.seg), 32'(7'b1000000));
        check("d0_lit_an",  32'(bus.an),  32'(4'b1110));
        check("d0_lit_frame", 32'(bus.frame), 32'd1);
        step("d1", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("d1_lit_seg", 32'(bus.seg), 32'(7'b0000000));
        // Mid-frame load must not tear the current frame.
        step("ldffff", 1'b0, 1'b1, 16'hFFFF, 4'h0, 4'h0, 4'h0);
        step("d2", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("d2_lit_seg", 32'(bus.seg), 32'(7'b0001000));
        step("d3", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("d3_lit_seg", 32'(bus.seg), 32'(7'b1111001));
        check("d3_lit_an",  32'(bus.an),  32'(4'b0111));
        for (int i = 0; i < 4; i++) begin
            step("fff", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
            check("fff_lit_seg", 32'(bus.seg), 32'(7'b0001110));
        end

        // Load coinciding with the wrap strobe.
        step("wrapld", 1'b1, 1'b1, 16'h0008, 4'h0, 4'h0, 4'h0);
        check("wrapld_lit_seg", 32'(bus.seg), 32'(7'b0000000));
        for (int i = 0; i < 3; i++)
            step("wrapld_rest", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

        // Blank and decimal point.
        step("ldbl", 1'b0, 1'b1, 16'h4321, 4'b0001, 4'b0100, 4'h0);
        for (int i = 0; i < 4; i++)
            step("bl", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        step("bl_d0", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("bl_d0_lit_dp", 32'(bus.dp), 32'd0);
        step("bl_d1", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        step("bl_d2", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        check("bl_d2_lit_seg", 32'(bus.seg), 32'(7'b1111111));
        check("bl_d2_lit_an",  32'(bus.an),  32'(4'b1011));

        // Blink over six frames from a fresh reset.
        do_reset();
        step("ldbk", 1'b0, 1'b1, 16'h0000, 4'h0, 4'h0, 4'b0001);
        for (int f = 0; f < 6; f++)
            for (int d = 0; d < NDIG; d++)
                step("blink", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

        // Randomized traffic with occasional asynchronous mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #3;
                greset = 1'b1;
                #1;
                model_reset();
                check_outputs("async_rst");
                step("rst_hold", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
                greset = 1'b0;
            end
            step("rand",
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom),
                 4'($urandom),
                 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 4'($urandom));
        end

        // Back-to-back strobes.
        for (int i = 0; i < 12; i++)
            step("b2b", 1'b1, ($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 4'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Multiplexed seven-segment display driver that consumes the `digsel` advance strobe from the clock-generation block and scans an NDIG-digit, common-anode display. It double-buffers a hex value, rotates a one-hot anode ring on each `digsel` pulse, and drives registered, active-low anode, segment and decimal-point outputs. It sits between the system logic running on `clk` and the board display pins.

## Interface
- `NDIG`, 4: number of digits scanned (2..8).
- `BLINK_DIV`, 64: completed frames per blink half-period; used only when blink is compiled in.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `greset`  in  1  reset, asynchronous, active-high.
- `digsel`  in  1  one-`clk`-cycle advance strobe.
- `load`  in  1  capture strobe for the shadow registers.
- `value`  in  4*NDIG  hex nibbles; nibble i drives digit i, with digit 0 rightmost.
- `dp_in`  in  NDIG  decimal point request per digit, active-high.
- `blank_in`  in  NDIG  forces digit i dark, active-high.
- `blink_in`  in  NDIG  blink request per digit; ignored unless blink is compiled in.
- `an`  out  NDIG  anode enables, active-low, one-hot-low when scanning.
- `seg`  out  7  segments, active-low; `seg[0]`=a through `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse on each wrap from digit NDIG-1 to digit 0.

## Operation
- Shadow register: captures `value`/`dp_in`/`blank_in`/`blink_in` on every cycle in which `load`=1. Capture is independent of `digsel`.
- Display register: copied from the shadow only on a wrap, so that no frame shows mixed old and new data.
- Wrap with simultaneous `load` on the same edge: the display register takes the incoming port values directly, bypassing the shadow.
- Scan state: a one-hot ring `ring[NDIG-1:0]` plus an `idle` flag.
  - Reset: `idle`=1 and `ring` points at digit NDIG-1.
  - Each `digsel`=1 cycle rotates `ring` by one digit position (i to i+1 mod NDIG) and clears `idle`.
  - A rotation from NDIG-1 to 0 is a wrap.
  - The first `digsel` after reset is therefore a wrap. It brings up digit 0 with the shadow contents.
- Output encoding for the selected digit i:
  - `an` = ~ring.
  - `seg` = hex7 of nibble i. Examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
  - `dp` = ~dp_i.
- Dark digit: if `blank_i` (or the blink condition) holds, `seg`=1111111 and `dp`=1 while `an` still selects the digit.
- `digsel` high on consecutive cycles: each cycle advances the ring once; there is no pulse-width filtering.
- `digsel` and `greset` together: reset wins.

## Timing
- Reset values: `an`=all 1, `seg`=1111111, `dp`=1, `frame`=0; shadow, display and blink state all 0.
- `an`, `seg`, `dp` and `frame` are registered. They change on the same edge that samples `digsel`=1 (1-edge latency) and hold between strobes.
- `load` to display: visible at the next wrap. Worst case is NDIG `digsel` pulses plus 1 edge.
- `frame` is high for exactly the cycle following the wrap edge.
- `greset` assertion mid-scan: outputs go to their reset values asynchronously. Scanning resumes from the idle state on the first `digsel` after release.

## Configuration
- `DISP_BLINK_EN` defined:
  - A frame counter counts wraps modulo BLINK_DIV and toggles a `phase` bit at each rollover.
  - While `phase`=1, digits with `blink_i`=1 are dark.
  - Counter and `phase` reset to 0.
- `DISP_BLINK_EN` undefined:
  - No counter and no `phase` bit.
  - `blink_in` is ignored; the port remains present.

## Structure
- Package `display_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - `seg7_t` typedef.
  - The 16-entry hex-to-segment constant table.
- Sub-module `hex7seg`: combinational nibble to active-low `seg7_t` lookup from the package table. It is instantiated once, on the muxed nibble.

## Test plan
- Reset, then no `digsel` for 100 cycles → `an`=1111, `seg`=1111111, `dp`=1, `frame`=0 throughout.
- `load` with `value`=16'h1A80, then 4 `digsel` pulses → digits 0..3 show `seg`=1000000, 0000000, 0001000, 1111001 with `an`=1110, 1101, 1011, 0111; `frame` pulses after the first strobe.
- Mid-frame (ring at digit 1): `load` 16'hFFFF → digits 2 and 3 still show the old value. After the next wrap all digits show 0001110.
- `load` asserted in the same cycle as the wrap strobe with `value`=16'h0008 → digit 0 immediately shows 0000000.
- `blank_in`=0100 and `dp_in`=0001 → digit 2 `seg`=1111111 with `an`=1011; digit 0 `dp`=0.
- With `DISP_BLINK_EN`, `BLINK_DIV`=2, `blink_in`=0001 → digit 0 is dark in frames 3–4 and lit in frames 1–2 and 5–6. `greset` pulsed mid-frame → outputs return to reset values within the same cycle.
